census_window_stream: RTL and testbench

//  Parametrised census-transform window for the stereo pipeline, the successor to the fixed 3x3

---
 rtl/census_window_stream_if.sv | 26 ++
 rtl/census_window_stream.sv | 133 +++++++++++++
 tb/tb_census_window_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/census_window_stream_if.sv
// Pixel-in / census-out stream bundle for census_window_stream.
// master = upstream/downstream side (bench or pipeline glue), slave = the census block.
interface census_window_stream_if #(
  parameter int PIX_W = 10,
  parameter int CEN_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [CEN_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/census_window_stream.sv
// Raster pixel stream -> BOX_W x BOX_H census strings over a valid/ready output register.
// Define CENSUS_THRESH_EN to add the thresh port (bit = neighbour > centre + thresh).
module census_window_stream #(
  parameter int PIX_W     = 10,
  parameter int BOX_W     = 5,
  parameter int BOX_H     = 5,
  parameter int IMG_WIDTH = 64,
  parameter int COL_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             census_en,
`ifdef CENSUS_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  census_window_stream_if.slave bus
);
  localparam int CEN_W   = BOX_W*BOX_H-1;
  localparam int ROW_W   = $clog2(BOX_H);
  localparam int IDX_W   = $clog2(IMG_WIDTH);
  localparam int CTR_IDX = (BOX_H/2)*BOX_W + BOX_W/2;
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH-1);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(BOX_W-1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(BOX_H-1);

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic [IDX_W-1:0] idx;
  logic             accept, complete, sof_pend;
  logic [PIX_W-1:0] lbuf  [BOX_H-1][IMG_WIDTH];
  logic [PIX_W-1:0] lb_rd [BOX_H-1];
  logic [PIX_W-1:0] win   [BOX_H][BOX_W];
  logic [PIX_W-1:0] nwin  [BOX_H][BOX_W];
  logic [PIX_W:0]   ref_level;
  logic [CEN_W-1:0] cen;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Position of the pixel being accepted; in_sof pins it to the frame origin.
  assign cur_col  = bus.in_sof ? '0 : col;
  assign cur_row  = bus.in_sof ? '0 : row;
  assign idx      = cur_col[IDX_W-1:0];
  assign complete = (cur_row == LAST_ROW) && (cur_col >= FIRST_COL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      sof_pend <= 1'b0;
    end else if (accept) begin
      if (cur_col == LAST_COL) begin
        col <= '0;
        row <= (cur_row == LAST_ROW) ? cur_row : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
      if (bus.in_sof)
        sof_pend <= 1'b1;
      else if (complete)
        sof_pend <= 1'b0;
    end
  end

  // Buffer 0 holds the previous row, buffer k the row k+1 above; contents are never cleared.
  for (genvar k = 0; k < BOX_H-1; k++) begin : g_lb_rd
    assign lb_rd[k] = lbuf[k][idx];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lbuf[0][idx] <= bus.in_pix;
      for (int k = 1; k < BOX_H-1; k++)
        lbuf[k][idx] <= lb_rd[k-1];
    end
  end

  always_comb begin
    for (int r = 0; r < BOX_H; r++)
      for (int c = 0; c < BOX_W-1; c++)
        nwin[r][c] = win[r][c+1];
    nwin[BOX_H-1][BOX_W-1] = bus.in_pix;
    for (int r = 0; r < BOX_H-1; r++)
      nwin[r][BOX_W-1] = lb_rd[BOX_H-2-r];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < BOX_H; r++)
        for (int c = 0; c < BOX_W; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      win <= nwin;
    end
  end

  // Compare at PIX_W+1 bits so centre + thresh cannot wrap.
`ifdef CENSUS_THRESH_EN
  assign ref_level = {1'b0, nwin[BOX_H/2][BOX_W/2]} + {1'b0, thresh};
`else
  assign ref_level = {1'b0, nwin[BOX_H/2][BOX_W/2]};
`endif

  for (genvar r = 0; r < BOX_H; r++) begin : g_row
    for (genvar c = 0; c < BOX_W; c++) begin : g_col
      localparam int IDX = r*BOX_W + c;
      if (IDX != CTR_IDX) begin : g_bit
        localparam int POS = (IDX < CTR_IDX) ? CEN_W-1-IDX : CEN_W-IDX;
        assign cen[POS] = ({1'b0, nwin[r][c]} > ref_level);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
    end else if (accept && complete) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= census_en ? cen : '0;
      bus.out_sof   <= sof_pend;
      bus.out_eol   <= (cur_col == LAST_COL);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_census_window_stream.sv
// Scoreboard bench for census_window_stream at 3x3 window, 8-pixel rows, 8-row frames.
`timescale 1ns/1ps
module tb_census_window_stream;
  localparam int PIX_W     = 10;
  localparam int BOX_W     = 3;
  localparam int BOX_H     = 3;
  localparam int IMG_WIDTH = 8;
  localparam int COL_W     = 7;
  localparam int CEN_W     = BOX_W*BOX_H-1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic census_en = 1'b1;
`ifdef CENSUS_THRESH_EN
  logic [PIX_W-1:0] thresh = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CEN_W-1:0] d;
    logic             s;
    logic             e;
  } exp_t;
  exp_t sb[$];

  census_window_stream_if #(.PIX_W(PIX_W), .CEN_W(CEN_W)) bus ();

  census_window_stream #(
    .PIX_W(PIX_W), .BOX_W(BOX_W), .BOX_H(BOX_H), .IMG_WIDTH(IMG_WIDTH), .COL_W(COL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .census_en(census_en),
`ifdef CENSUS_THRESH_EN
    .thresh(thresh),
`endif
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A word transfers at the next rising edge whenever valid && ready hold at the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=%0h with no word due, required none (t=%0t)", bus.out_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", bus.out_data, e.d);
        check("word_sof", bus.out_sof, e.s);
        check("word_eol", bus.out_eol, e.e);
      end
    end
  end

  task automatic send_pixel(input logic [PIX_W-1:0] pix, input logic sof);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_pix   = pix;
    bus.in_sof   = sof;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n >= 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
        break;
      end
    end
  endtask

  task automatic do_stall(input logic [PIX_W-1:0] pix, input logic [CEN_W-1:0] exp);
    bus.in_valid  = 1'b1;
    bus.in_pix    = pix;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, exp);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
  endtask

  // Streams n_pix pixels of a frame starting with in_sof; ramp pix = col + 16*row, or flat 100.
  task automatic run_frame(input bit flat, input logic [CEN_W-1:0] exp, input int n_pix,
                           input int stall_at, input bit lat);
    bit first;
    first = 1'b1;
    for (int p = 0; p < n_pix; p++) begin
      int r;
      int c;
      logic [PIX_W-1:0] pix;
      r = p / IMG_WIDTH;
      c = p % IMG_WIDTH;
      pix = flat ? PIX_W'(100) : PIX_W'(c + 16*r);
      if (r >= BOX_H-1 && c >= BOX_W-1) begin
        sb.push_back('{d: exp, s: first, e: (c == IMG_WIDTH-1)});
        first = 1'b0;
      end
      if (p == stall_at)
        do_stall(pix, exp);
      send_pixel(pix, p == 0);
      if (lat && p == 17) check("latency_before_first", bus.out_valid, 0);
      if (lat && p == 18) check("latency_first_word", bus.out_valid, 1);
    end
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending_words", sb.size(), 0);
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_out_data", bus.out_data, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_sof", bus.out_sof, 0);
    check("reset_out_eol", bus.out_eol, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_frame(1'b0, 8'h0F, 64, -1, 1'b1);
    drain();

    run_frame(1'b1, 8'h00, 64, -1, 1'b0);
    drain();

    run_frame(1'b0, 8'h0F, 64, 36, 1'b0);
    drain();

    run_frame(1'b0, 8'h0F, 28, -1, 1'b0);
    run_frame(1'b0, 8'h0F, 64, -1, 1'b0);
    drain();

    // Reset while the row-4 col-4 word is held; that word is lost with the partial frame.
    run_frame(1'b0, 8'h0F, 37, -1, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_out_data", bus.out_data, 0);
    check("midreset_out_sof", bus.out_sof, 0);
    check("midreset_out_eol", bus.out_eol, 0);
    check("midreset_in_ready", bus.in_ready, 1);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_frame(1'b0, 8'h0F, 64, -1, 1'b1);
    drain();

    census_en = 1'b0;
    run_frame(1'b0, 8'h00, 64, -1, 1'b0);
    drain();
    census_en = 1'b1;

`ifdef CENSUS_THRESH_EN
    thresh = 10'd1;
    run_frame(1'b0, 8'h07, 64, -1, 1'b0);
    drain();
    thresh = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
